// File: rtl/acc_pkg.sv
// Shared types and image constants for the accelerator chain.
package acc_pkg;

    localparam int unsigned IMG_W_WORDS = 88;
    localparam int unsigned IMG_H       = 288;
    localparam int unsigned IMG_WORDS   = 25344;
    localparam int unsigned RESULT_BASE = 25344;

    typedef logic [31:0] word_t;
    typedef logic [15:0] halfword_t;

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} thr_state_t;

endpackage

// File: rtl/acc_thresh_if.sv
// Word-memory bus plus start/finish handshake shared by the accelerators.
interface acc_thresh_if;
    import acc_pkg::*;

    halfword_t addr;
    word_t     dataR;
    word_t     dataW;
    logic      en;
    logic      we;
    logic      start;
    logic      finish;

    // The accelerator masters the memory bus and reports finish to the sequencer.
    modport master (
        output addr, dataW, en, we, finish,
        input  dataR, start
    );

    modport slave (
        input  addr, dataW, en, we, finish,
        output dataR, start
    );

endinterface

// File: rtl/acc_thresh_thresh4.sv
// Binarizes the four bytes of a word against a threshold and counts the marked bytes.
module thresh4
    import acc_pkg::*;
(
    input  word_t       din,
    input  logic [7:0]  thr,
    output word_t       bin,
    output logic [2:0]  cnt
);

    always_comb begin
        bin = '0;
        cnt = '0;
        for (int k = 0; k < 4; k++) begin
            if (din[8*k +: 8] >= thr) begin
                bin[8*k +: 8] = 8'hFF;
                cnt           = cnt + 3'd1;
            end
        end
    end

endmodule

// File: rtl/acc_thresh.sv
// Threshold stage: read word, binarize, write back; 2 cycles per word.
// Edge counting is built only when ACC_THRESH_EDGE_COUNT_EN is defined.
module acc_thresh
    import acc_pkg::*;
#(
    parameter int unsigned IMG_WORDS = acc_pkg::IMG_WORDS,
    parameter int unsigned SRC_BASE  = acc_pkg::RESULT_BASE,
    parameter int unsigned DST_BASE  = acc_pkg::RESULT_BASE
) (
    input  logic          clk,
    input  logic          reset,
    acc_thresh_if.master  bus,
    input  logic [7:0]    threshold,
    output logic [16:0]   edge_count
);

    localparam halfword_t SrcBase = halfword_t'(SRC_BASE);
    localparam halfword_t DstBase = halfword_t'(DST_BASE);
    localparam halfword_t LastIdx = halfword_t'(IMG_WORDS - 1);

    thr_state_t state;
    halfword_t  idx;
    logic [7:0] thr_q;
    logic       finish_q;
    word_t      bin;
    logic [2:0] cnt;

    thresh4 u_thresh4 (
        .din (bus.dataR),
        .thr (thr_q),
        .bin (bin),
        .cnt (cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            thr_q    <= '0;
            finish_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        thr_q <= threshold;
                        idx   <= '0;
                        state <= RD;
                    end
                end
                RD: state <= WR;
                WR: begin
                    if (idx == LastIdx) begin
                        state <= DONE;
                    end else begin
                        idx   <= idx + 16'd1;
                        state <= RD;
                    end
                end
                DONE: begin
                    // finish is raised one cycle after entering DONE and drops with the exit.
                    finish_q <= 1'b1;
                    if (finish_q && !bus.start) begin
                        finish_q <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ACC_THRESH_EDGE_COUNT_EN
    logic [16:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (state == IDLE && bus.start) begin
            count_q <= '0;
        end else if (state == WR) begin
            count_q <= count_q + 17'(cnt);
        end
    end

    assign edge_count = count_q;
`else
    logic unused_cnt;
    assign unused_cnt = ^cnt;
    assign edge_count = '0;
`endif

    always_comb begin
        bus.en    = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = '0;
        bus.dataW = '0;
        case (state)
            RD: begin
                bus.en   = 1'b1;
                bus.addr = SrcBase + idx;
            end
            WR: begin
                bus.en    = 1'b1;
                bus.we    = 1'b1;
                bus.addr  = DstBase + idx;
                bus.dataW = bin;
            end
            default: ;
        endcase
    end

    assign bus.finish = finish_q;

endmodule

// File: tb/tb_acc_thresh.sv
// Scoreboard bench for acc_thresh with a small word memory model.
module tb_acc_thresh;

    localparam int unsigned N    = 8;
    localparam int unsigned SRC  = 0;
    localparam int unsigned DST  = 100;
    localparam logic [31:0] SENT = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  threshold;
    logic [16:0] edge_count;
    logic [31:0] rdata;

    logic [31:0] mem [0:255];
    logic [31:0] src_img [0:N-1];
    logic [31:0] exp_img [0:N-1];
    logic [31:0] sb_q [$];

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt;
    int rd_idx = 0;
    int wr_idx = 0;
    bit exp_we = 1'b0;

    acc_thresh_if bus ();

    acc_thresh #(
        .IMG_WORDS (N),
        .SRC_BASE  (SRC),
        .DST_BASE  (DST)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .threshold  (threshold),
        .edge_count (edge_count)
    );

    always #5 clk = ~clk;

    assign bus.dataR = rdata;

    always @(posedge clk) begin
        if (bus.en) begin
            if (bus.we) mem[bus.addr[7:0]] <= bus.dataW;
            else        rdata <= mem[bus.addr[7:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] w, input logic [7:0] thr,
                                          output int n);
        logic [31:0] r;
        logic [7:0]  b;
        r = '0;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            b = w[8*k +: 8];
            if (b >= thr) begin
                r[8*k +: 8] = 8'hFF;
                n++;
            end
        end
        return r;
    endfunction

    // Bus monitor: strict RD/WR alternation, addresses, and written data vs scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            rd_idx = 0;
            wr_idx = 0;
            exp_we = 1'b0;
            sb_q.delete();
        end else if (bus.en) begin
            chk("we_alt", {31'd0, bus.we}, {31'd0, exp_we});
            if (bus.we) begin
                chk("wr_addr", {16'd0, bus.addr}, DST + wr_idx);
                if (sb_q.size() == 0) chk("sb_underflow", bus.dataW, SENT);
                else                  chk("wr_data", bus.dataW, sb_q.pop_front());
                wr_idx = (wr_idx + 1) % N;
            end else begin
                chk("rd_addr", {16'd0, bus.addr}, SRC + rd_idx);
                rd_idx = (rd_idx + 1) % N;
            end
            exp_we = ~exp_we;
        end
    end

    task automatic load(input logic [31:0] w, input bit rnd, input logic [7:0] thr);
        int n;
        exp_cnt = 0;
        for (int i = 0; i < N; i++) begin
            src_img[i]  = rnd ? $urandom : w;
            mem[SRC+i]  = src_img[i];
            mem[DST+i]  = SENT;
            exp_img[i]  = model(src_img[i], thr, n);
            exp_cnt    += n;
            sb_q.push_back(exp_img[i]);
        end
    endtask

    task automatic run(input logic [7:0] thr, input bit hold, input int abort_at);
        int k;
        threshold = thr;
        bus.start = 1'b1;
        @(posedge clk); #1;
        chk("cnt_clear", {15'd0, edge_count}, 32'd0);
        if (!hold) bus.start = 1'b0;
        threshold = ~thr;
        k = 1;
        while (k < 100) begin
            if (abort_at == k) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                chk("rst_en", {31'd0, bus.en}, 32'd0);
                chk("rst_fin", {31'd0, bus.finish}, 32'd0);
                chk("rst_cnt", {15'd0, edge_count}, 32'd0);
                return;
            end
            @(posedge clk); #1;
            if (bus.finish) break;
            k++;
        end
        chk("fin_lat", k, 2 * N + 1);
        chk("done_en", {31'd0, bus.en}, 32'd0);
`ifdef ACC_THRESH_EDGE_COUNT_EN
        chk("edge_cnt", {15'd0, edge_count}, exp_cnt);
`else
        chk("edge_cnt", {15'd0, edge_count}, 32'd0);
`endif
        chk("sb_drain", sb_q.size(), 32'd0);
        for (int i = 0; i < N; i++) begin
            chk("dst_word", mem[DST+i], exp_img[i]);
            chk("src_keep", mem[SRC+i], src_img[i]);
        end
        chk("dst_below", mem[DST-1], SENT);
        chk("dst_above", mem[DST+N], SENT);
        if (!hold) begin
            @(posedge clk); #1;
            chk("idle_fin", {31'd0, bus.finish}, 32'd0);
            chk("idle_en", {31'd0, bus.en}, 32'd0);
        end
    endtask

    initial begin
        logic [16:0] held;
        for (int i = 0; i < 256; i++) mem[i] = SENT;
        rdata     = '0;
        reset     = 1'b1;
        bus.start = 1'b0;
        threshold = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_en0", {31'd0, bus.en}, 32'd0);
        chk("rst_we0", {31'd0, bus.we}, 32'd0);
        chk("rst_addr0", {16'd0, bus.addr}, 32'd0);
        chk("rst_dataw0", bus.dataW, 32'd0);
        chk("rst_fin0", {31'd0, bus.finish}, 32'd0);
        chk("rst_cnt0", {15'd0, edge_count}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        load(32'h007F80FF, 1'b0, 8'h80);
        chk("model_80", exp_img[0], 32'h0000FFFF);
        run(8'h80, 1'b0, 0);

        load(32'h0, 1'b1, 8'h00);
        chk("model_00", exp_img[0], 32'hFFFFFFFF);
        run(8'h00, 1'b0, 0);

        load(32'hFF00FFFE, 1'b0, 8'hFF);
        chk("model_ff", exp_img[0], 32'hFF00FF00);
        run(8'hFF, 1'b0, 0);

        // Hold start through DONE, then release.
        load(32'h0, 1'b1, 8'h80);
        run(8'h80, 1'b1, 0);
        held = edge_count;
        repeat (3) begin
            @(posedge clk); #1;
            chk("hold_fin", {31'd0, bus.finish}, 32'd1);
            chk("hold_en", {31'd0, bus.en}, 32'd0);
        end
        bus.start = 1'b0;
        @(posedge clk); #1;
        chk("rel_fin", {31'd0, bus.finish}, 32'd0);
        chk("rel_en", {31'd0, bus.en}, 32'd0);
        chk("rel_cnt", {15'd0, edge_count}, {15'd0, held});

        // Reset during WR of idx 3, then a full clean pass.
        load(32'h0, 1'b1, 8'h40);
        run(8'h40, 1'b0, 8);
        @(posedge clk); #1;
        load(32'h0, 1'b1, 8'h40);
        run(8'h40, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/acc_thresh.md
Name: acc_thresh

Overview:
- Post-processing stage directly downstream of the Sobel edge accelerator.
- Reads the Sobel result image from shared word memory, binarizes every pixel against a runtime threshold, and writes the binary image back to memory.
- Optionally counts edge pixels.
- Uses the same memory bus and start/finish handshake as the other accelerators, so the top-level sequencer can chain it after the Sobel stage.

Parameters:
- IMG_WORDS, 25344, number of 32-bit words in the image (352x288 pixels / 4).
- SRC_BASE, 25344, word address of the first source word (Sobel output region).
- DST_BASE, 25344, word address of the first destination word. The default processes in place.

Ports:
- clk  input  1  clock.
- reset  input  1  reset.
- addr  output  16  word address for memory.
- dataR  input  32  read data; valid the cycle after a read request.
- dataW  output  32  write data.
- en  output  1  memory request.
- we  output  1  1 = write, 0 = read; meaningful only when en=1.
- start  input  1  level request to run.
- finish  output  1  run complete.
- threshold  input  8  binarization threshold; sampled when a run starts.
- edge_count  output  17  number of pixels >= threshold in the last run.

Clock and reset (already decided): one clock, clk; reset is synchronous and active-high, named reset.

Behaviour:
- Reset values: state IDLE; en=0, we=0, addr=0, dataW=0, finish=0, edge_count=0; word index idx=0.
- Output timing: en, we, addr and dataW are combinational from state, idx and dataR only. No combinational path from start to any output.
- Pixel rule: byte k of a word maps to dataR[8k+7:8k]. Output byte = 8'hFF if pixel >= thr_q (unsigned compare), else 8'h00. Byte order is preserved.
- IDLE:
  - All memory outputs are 0.
  - On start=1: thr_q <= threshold, idx <= 0, count <= 0, then go to RD.
- RD:
  - Drive en=1, we=0, addr=SRC_BASE+idx.
  - Always go to WR.
- WR:
  - Drive en=1, we=1, addr=DST_BASE+idx, dataW = binarize(dataR).
  - count <= count + number of bytes >= thr_q.
  - If idx==IMG_WORDS-1, go to DONE; otherwise idx <= idx+1 and go to RD.
- DONE:
  - finish=1 and en=0.
  - Stay while start=1. Go to IDLE on the first cycle start=0.
- Throughput and latency:
  - 2 cycles per word; 2*IMG_WORDS cycles busy.
  - finish first high exactly 2*IMG_WORDS+1 cycles after the clock edge that sampled start=1 in IDLE.
- In-place safety: word i is always read (RD) before it is written (WR), so SRC_BASE==DST_BASE is legal.
- start changes during RD/WR are ignored. threshold changes after sampling are ignored.
- edge_count holds its value through DONE and IDLE. It clears only when a new run starts.
- Address arithmetic is 16-bit and wraps modulo 2^16. SRC_BASE+IMG_WORDS <= 65536 and DST_BASE+IMG_WORDS <= 65536 are integrator obligations and are not checked.
- Reset asserted mid-run: the next cycle is IDLE with all reset values. Already-written words stay written and the run is not resumed.
- Thresholds 0 and 255:
  - thr=0 marks every pixel, giving edge_count = 4*IMG_WORDS (max 101376, fits 17 bits).
  - thr=255 marks only bytes equal to 255.

Optional Feature:
- Macro: ACC_THRESH_EDGE_COUNT_EN.
- Defined: the counter logic is built and edge_count behaves as above.
- Not defined: no counter is synthesized and edge_count is tied to 0. The port list is unchanged.

Decomposition:
- Shared package acc_pkg holds:
  - Constants IMG_W_WORDS=88, IMG_H=288, IMG_WORDS=25344, RESULT_BASE=25344.
  - typedef word_t (32-bit) and halfword_t (16-bit).
  - enum thr_state_t {IDLE, RD, WR, DONE}.
- One sub-module, thresh4: purely combinational. Inputs: 32-bit word and 8-bit threshold. Outputs: binarized 32-bit word and a 3-bit count (0..4).
- The FSM, index counter and count accumulator live in acc_thresh.

Test Plan:
- Run with IMG_WORDS=8 (simulation override), threshold=8'h80, memory words 32'h00_7F_80_FF -> written 32'h00_00_FF_FF per word; edge_count=16; finish rises at cycle 17.
- Run with threshold=0 over a random image -> every destination word is 32'hFFFFFFFF; edge_count=4*IMG_WORDS.
- Run with threshold=255 on bytes {FE,FF,00,FF} -> written 32'hFF00FF00; count 2 per word.
- Run with SRC_BASE=0, DST_BASE=100 -> source region unchanged; writes only to 100..100+IMG_WORDS-1; bus shows strict alternation RD(we=0), WR(we=1).
- Hold start high through DONE, then drop it -> finish stays 1 until start=0, next cycle IDLE with finish=0; edge_count retained; a new start clears edge_count.
- Assert reset for 1 cycle at idx=3 during WR -> next cycle en=0, finish=0, edge_count=0; a subsequent start runs a complete, correct pass.
